// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with valid/ready output and multi-hot flag.
// Define RR_PRIORITY_ENCODER_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module rr_priority_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_multi
);

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         multi_q, multi_d;
  logic         load;
  logic [W-1:0] sel;

  assign load = !valid_q || out_ready;

`ifdef RR_PRIORITY_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Pointer wraps at N, not 2^W, so non-power-of-two N never points past the last line.
  always_comb begin
    ptr_d = ptr_q;
    if (load && (|req)) begin
      ptr_d = (sel == W'(N - 1)) ? '0 : sel + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic [W-1:0] ptr_q;
  assign ptr_q = '0;
`endif

  always_comb begin : scan
    logic found;
    int   j;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = W'(j);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    if (load) begin
      if (|req) begin
        valid_d = 1'b1;
        idx_d   = sel;
        multi_d = |(req & (req - N'(1)));
      end else begin
        valid_d = 1'b0;
        multi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_multi = multi_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder (N=8 and N=5 instances); expectations follow
// RR_PRIORITY_ENCODER_ROUND_ROBIN_EN when it is defined for the build.
module tb_rr_priority_encoder;

`ifdef RR_PRIORITY_ENCODER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_multi;

  logic [4:0] req5;
  logic       ready5;
  logic       valid5;
  logic [2:0] idx5;
  logic       multi5;

  int total = 0;
  int bad   = 0;

  rr_priority_encoder #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .out_multi(out_multi)
  );

  rr_priority_encoder #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .out_ready(ready5),
    .out_valid(valid5), .out_idx(idx5), .out_multi(multi5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect8(input string tag, input logic v, input logic [2:0] i, input logic m);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".idx"},   32'(out_idx),   32'(i));
    check({tag, ".multi"}, 32'(out_multi), 32'(m));
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b0; req5 = '0; ready5 = 1'b1;
    #2;
    expect8("reset", 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;

    // one-hot
    req = 8'h10; out_ready = 1'b1;
    step();
    expect8("onehot", 1'b1, 3'd4, 1'b0);

    // async reset between edges, then rotation from ptr=0
    #2 rst_n = 1'b0;
    #1 expect8("rst2", 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      expect8($sformatf("rot%0d", k), 1'b1, RR ? 3'(k % 8) : 3'd0, 1'b1);
    end

    // drive ptr to 6, then wrap scan 6,7,0
    req = 8'h20;
    step();
    expect8("pre_wrap", 1'b1, 3'd5, 1'b0);
    req = 8'b0000_0101;
    step();
    expect8("wrap", 1'b1, 3'd0, 1'b1);
    step();
    expect8("wrap_ptr1", 1'b1, RR ? 3'd2 : 3'd0, 1'b1);

    // backpressure
    req = 8'h08;
    step();
    expect8("bp_load", 1'b1, 3'd3, 1'b0);
    out_ready = 1'b0; req = 8'h80;
    for (int k = 0; k < 4; k++) begin
      step();
      expect8($sformatf("bp_hold%0d", k), 1'b1, 3'd3, 1'b0);
    end
    out_ready = 1'b1;
    step();
    expect8("bp_release", 1'b1, 3'd7, 1'b0);

    // zero request after a multi-hot result; ptr must survive
    req = 8'h0C;
    step();
    expect8("multi", 1'b1, 3'd2, 1'b1);
    req = 8'h00;
    step();
    expect8("zero", 1'b0, 3'd2, 1'b0);
    req = 8'h0C;
    step();
    expect8("after_zero", 1'b1, RR ? 3'd3 : 3'd2, 1'b1);

    // async reset during a stall
    req = 8'h40;
    step();
    expect8("stall_load", 1'b1, 3'd6, 1'b0);
    out_ready = 1'b0;
    step();
    expect8("stall", 1'b1, 3'd6, 1'b0);
    #3 rst_n = 1'b0;
    #1 expect8("rst_stall", 1'b0, 3'd0, 1'b0);
    #1 rst_n = 1'b1;
    req = 8'h02; out_ready = 1'b1;
    step();
    expect8("post_rst", 1'b1, 3'd1, 1'b0);

    // N=5: pointer wraps at 5
    req5 = 5'b01000;
    step();
    check("n5_a.idx", 32'(idx5), 32'd3);
    check("n5_a.valid", 32'(valid5), 32'd1);
    req5 = 5'b00011;
    step();
    check("n5_b.idx", 32'(idx5), 32'd0);
    check("n5_b.multi", 32'(multi5), 32'd1);
    step();
    check("n5_c.idx", 32'(idx5), RR ? 32'd1 : 32'd0);
    req5 = 5'b10000;
    step();
    check("n5_d.idx", 32'(idx5), 32'd4);
    req5 = 5'b00110;
    step();
    check("n5_e.idx", 32'(idx5), 32'd1);
    check("n5_e.multi", 32'(multi5), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
